// File: rtl/vga_axil_slave_if.sv
// AXI4-Lite bus bundle between a master and the VGA AXI4-Lite slave front-end.
// Field names follow the AXI channel signals without the s_axi_ prefix.
interface vga_axil_slave_if #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 15
);
  localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;

  logic                        awvalid;
  logic                        awready;
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                  awprot;

  logic                        wvalid;
  logic                        wready;
  logic [C_AXI_DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]           wstrb;

  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;

  logic                        arvalid;
  logic                        arready;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                  arprot;

  logic                        rvalid;
  logic                        rready;
  logic [C_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                  rresp;

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );
endinterface

// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave front-end for the VGA controller: terminates the AXI channels
// and drives the core's write-pulse / read-request strobe interface.
module vga_axil_slave #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 15,
  parameter int unsigned ADDRLSB          = $clog2(C_AXI_DATA_WIDTH) - 3,
  parameter int unsigned RD_LATENCY       = 2
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  vga_axil_slave_if.slave               s_axi,
  output logic                          axil_wready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic                          axil_rreq_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i
);

  localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_MASK =
    ~C_AXI_ADDR_WIDTH'((1 << ADDRLSB) - 1);

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_ISSUE   = 2'd1,
    W_RESP    = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic             aw_full, w_full;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             bvalid_q, rvalid_q;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_prot;

  // Ready signals are held low while reset is asserted.
  assign s_axi.awready = rstn_i & ~aw_full;
  assign s_axi.wready  = rstn_i & ~w_full;
  assign s_axi.arready = rstn_i & (r_state_q == R_IDLE);

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = 2'b00;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = 2'b00;

  assign aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_hs  = s_axi.wvalid  & s_axi.wready;
  assign b_hs  = bvalid_q      & s_axi.bready;
  assign ar_hs = s_axi.arvalid & s_axi.arready;
  assign r_hs  = rvalid_q      & s_axi.rready;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  // Write path next-state
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_COLLECT: if (aw_full && w_full) w_state_d = W_ISSUE;
      W_ISSUE:   w_state_d = W_RESP;
      W_RESP:    if (b_hs) w_state_d = W_COLLECT;
      default:   w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state_q     <= W_COLLECT;
      axil_wready_o <= 1'b0;
      bvalid_q      <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      axil_wready_o <= (w_state_d == W_ISSUE);
      bvalid_q      <= (w_state_d == W_RESP);
    end
  end

  // Capture flags and holding registers; released only by the B handshake.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      axil_waddr_o <= '0;
      axil_wdata_o <= '0;
      axil_wstrb_o <= '0;
    end else if (b_hs) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full      <= 1'b1;
        axil_waddr_o <= s_axi.awaddr & ADDR_MASK;
      end
      if (w_hs) begin
        w_full       <= 1'b1;
        axil_wdata_o <= s_axi.wdata;
        axil_wstrb_o <= STRB_W'(s_axi.wstrb);
      end
    end
  end

  // Read path next-state and latency counter
  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) r_state_d = R_REQ;
      R_REQ: begin
        cnt_d     = CNT_W'(RD_LATENCY - 1);
        r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (cnt_q == '0) r_state_d = R_RESP;
        else             cnt_d     = cnt_q - CNT_W'(1);
      end
      R_RESP: if (r_hs) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state_q   <= R_IDLE;
      cnt_q       <= '0;
      axil_rreq_o <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      cnt_q       <= cnt_d;
      axil_rreq_o <= (r_state_d == R_REQ);
      rvalid_q    <= (r_state_d == R_RESP);
    end
  end

  // Read address and returned data holding registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      axil_raddr_o <= '0;
      rdata_q      <= '0;
    end else begin
      if (ar_hs) axil_raddr_o <= s_axi.araddr & ADDR_MASK;
      if (r_state_q == R_WAIT && cnt_q == '0) rdata_q <= axil_rdata_i;
    end
  end

endmodule

// File: tb/tb_vga_axil_slave.sv
// Directed bench for vga_axil_slave: table-driven write/read transactions plus
// hand sequences for concurrency and mid-transaction reset.
module tb_vga_axil_slave;

  logic        clk;
  logic        rstn;
  logic        axil_wready;
  logic [14:0] axil_waddr;
  logic [31:0] axil_wdata;
  logic [3:0]  axil_wstrb;
  logic        axil_rreq;
  logic [14:0] axil_raddr;
  logic [31:0] axil_rdata;
  logic [31:0] core_val;

  int checks   = 0;
  int failures = 0;
  int wpulses  = 0;
  int rpulses  = 0;
  int bcount   = 0;
  int rcount   = 0;
  int since    = 0;
  bit both_seen = 0;
  logic [14:0] wq[$];
  logic [14:0] rq[$];

  vga_axil_slave_if #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(15)) axi();

  vga_axil_slave #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(15), .ADDRLSB(2), .RD_LATENCY(2)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .s_axi(axi),
    .axil_wready_o(axil_wready), .axil_waddr_o(axil_waddr),
    .axil_wdata_o(axil_wdata), .axil_wstrb_o(axil_wstrb),
    .axil_rreq_o(axil_rreq), .axil_raddr_o(axil_raddr),
    .axil_rdata_i(axil_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: data is valid only in the cycle the slave must sample it
  // (two edges after the edge that sees the request), garbage otherwise.
  assign axil_rdata = (since == 2) ? core_val : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (axil_rreq)      since <= 1;
    else if (since > 0) since <= (since > 8) ? 9 : since + 1;
    if (axil_wready) begin wpulses <= wpulses + 1; wq.push_back(axil_waddr); end
    if (axil_rreq)   begin rpulses <= rpulses + 1; rq.push_back(axil_raddr); end
    if (axil_wready && axil_rreq) both_seen <= 1'b1;
    if (axi.bvalid && axi.bready) bcount <= bcount + 1;
    if (axi.rvalid && axi.rready) rcount <= rcount + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h req=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [14:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gap;       // >0: W leads AW by gap cycles; <0: AW leads W
    logic [14:0] exp_waddr;
  } wvec_t;

  typedef struct {
    logic [14:0] araddr;
    logic [31:0] data;
    int          stall;
    logic [14:0] exp_raddr;
  } rvec_t;

  task automatic drive_aw(input logic [14:0] a);
    axi.awvalid = 1'b1; axi.awaddr = a;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    axi.wvalid = 1'b1; axi.wdata = d; axi.wstrb = s;
  endtask

  task automatic do_write(input wvec_t v);
    int p0, b0, ag;
    p0 = wpulses; b0 = bcount;
    ag = (v.gap < 0) ? -v.gap : v.gap;
    check("awready_idle", 32'(axi.awready), 32'd1);
    check("wready_idle", 32'(axi.wready), 32'd1);
    if (v.gap == 0) begin
      drive_aw(v.awaddr); drive_w(v.wdata, v.wstrb);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    end else begin
      if (v.gap > 0) drive_w(v.wdata, v.wstrb); else drive_aw(v.awaddr);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      repeat (ag - 1) @(negedge clk);
      check("no_early_pulse", 32'(wpulses - p0), 32'd0);
      if (v.gap > 0) check("wready_held_low", 32'(axi.wready), 32'd0);
      else           check("awready_held_low", 32'(axi.awready), 32'd0);
      if (v.gap > 0) drive_aw(v.awaddr); else drive_w(v.wdata, v.wstrb);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    end
    check("pulse_not_yet", 32'(axil_wready), 32'd0);
    @(negedge clk);
    check("pulse_high", 32'(axil_wready), 32'd1);
    check("waddr", 32'(axil_waddr), 32'(v.exp_waddr));
    check("wdata", axil_wdata, v.wdata);
    check("wstrb", 32'(axil_wstrb), 32'(v.wstrb));
    @(negedge clk);
    check("pulse_one_cycle", 32'(axil_wready), 32'd0);
    check("waddr_held", 32'(axil_waddr), 32'(v.exp_waddr));
    check("wdata_held", axil_wdata, v.wdata);
    check("bvalid", 32'(axi.bvalid), 32'd1);
    check("bresp", 32'(axi.bresp), 32'd0);
    check("awready_busy", 32'(axi.awready), 32'd0);
    check("wready_busy", 32'(axi.wready), 32'd0);
    @(negedge clk);
    check("bvalid_held", 32'(axi.bvalid), 32'd1);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check("bvalid_cleared", 32'(axi.bvalid), 32'd0);
    check("awready_free", 32'(axi.awready), 32'd1);
    check("wpulse_count", 32'(wpulses - p0), 32'd1);
    check("b_count", 32'(bcount - b0), 32'd1);
  endtask

  task automatic do_read(input rvec_t v);
    int p0;
    p0 = rpulses;
    check("arready_idle", 32'(axi.arready), 32'd1);
    axi.arvalid = 1'b1; axi.araddr = v.araddr; core_val = v.data;
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("rreq_high", 32'(axil_rreq), 32'd1);
    check("raddr", 32'(axil_raddr), 32'(v.exp_raddr));
    check("arready_busy", 32'(axi.arready), 32'd0);
    @(negedge clk);
    check("rreq_one_cycle", 32'(axil_rreq), 32'd0);
    check("rvalid_early1", 32'(axi.rvalid), 32'd0);
    @(negedge clk);
    check("rvalid_early2", 32'(axi.rvalid), 32'd0);
    @(negedge clk);
    check("rvalid", 32'(axi.rvalid), 32'd1);
    check("rdata", axi.rdata, v.data);
    check("rresp", 32'(axi.rresp), 32'd0);
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      check("rvalid_stall", 32'(axi.rvalid), 32'd1);
      check("rdata_stall", axi.rdata, v.data);
      check("arready_stall", 32'(axi.arready), 32'd0);
      check("raddr_stall", 32'(axil_raddr), 32'(v.exp_raddr));
    end
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check("rvalid_cleared", 32'(axi.rvalid), 32'd0);
    check("arready_free", 32'(axi.arready), 32'd1);
    check("rpulse_count", 32'(rpulses - p0), 32'd1);
  endtask

  initial begin
    wvec_t wv[4];
    rvec_t rv[3];
    logic [14:0] bwa[2];
    logic [14:0] bra[2];
    int wi, ri, p0w, p0r, b0, r0;
    bit hs_w, hs_r;

    wv[0] = '{15'h4004, 32'h4142_4344, 4'hF,  0, 15'h4004};
    wv[1] = '{15'h2003, 32'h1122_3344, 4'h3,  3, 15'h2000};
    wv[2] = '{15'h7FFE, 32'hCAFE_F00D, 4'hC, -2, 15'h7FFC};
    wv[3] = '{15'h0001, 32'hFFFF_FFFF, 4'h1,  1, 15'h0000};
    rv[0] = '{15'h2008, 32'h0000_000F, 5, 15'h2008};
    rv[1] = '{15'h7FFF, 32'hA5A5_A5A5, 0, 15'h7FFC};
    rv[2] = '{15'h0003, 32'h1234_5678, 2, 15'h0000};

    rstn = 1'b0; core_val = '0;
    axi.awvalid = 0; axi.awaddr = '0; axi.awprot = 3'd5;
    axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0;
    axi.bready = 0;
    axi.arvalid = 0; axi.araddr = '0; axi.arprot = 3'd2;
    axi.rready = 0;

    repeat (3) @(negedge clk);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_wready", 32'(axi.wready), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_pulses", 32'({axil_wready, axil_rreq}), 32'd0);
    check("rst_hold", 32'({axil_waddr, axil_raddr, axil_wstrb}), 32'd0);
    check("rst_wdata", axil_wdata, 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);

    for (int i = 0; i < 4; i++) do_write(wv[i]);
    for (int i = 0; i < 3; i++) do_read(rv[i]);

    // Interleaved writes and reads with bready/rready tied high
    bwa[0] = 15'h1000; bwa[1] = 15'h1107;
    bra[0] = 15'h0200; bra[1] = 15'h0306;
    wq.delete(); rq.delete();
    p0w = wpulses; p0r = rpulses; b0 = bcount; r0 = rcount;
    wi = 0; ri = 0; core_val = 32'h5555_AAAA;
    axi.bready = 1'b1; axi.rready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (!axi.awvalid && wi < 2) begin
        drive_aw(bwa[wi]); drive_w(32'h100 + 32'(wi), 4'hF);
      end
      if (!axi.arvalid && ri < 2 && c >= 1) begin
        axi.arvalid = 1'b1; axi.araddr = bra[ri];
      end
      hs_w = axi.awvalid && axi.awready && axi.wvalid && axi.wready;
      hs_r = axi.arvalid && axi.arready;
      @(negedge clk);
      if (hs_w) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; wi++; end
      if (hs_r) begin axi.arvalid = 1'b0; ri++; end
      if (wi == 2 && ri == 2) break;
    end
    repeat (8) @(negedge clk);
    axi.bready = 1'b0; axi.rready = 1'b0;
    check("b2b_wpulses", 32'(wpulses - p0w), 32'd2);
    check("b2b_rpulses", 32'(rpulses - p0r), 32'd2);
    check("b2b_bresps", 32'(bcount - b0), 32'd2);
    check("b2b_rresps", 32'(rcount - r0), 32'd2);
    check("b2b_wq_size", 32'(wq.size()), 32'd2);
    check("b2b_rq_size", 32'(rq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("b2b_waddr0", 32'(wq[0]), 32'h1000);
      check("b2b_waddr1", 32'(wq[1]), 32'h1104);
    end
    if (rq.size() == 2) begin
      check("b2b_raddr0", 32'(rq[0]), 32'h0200);
      check("b2b_raddr1", 32'(rq[1]), 32'h0304);
    end
    check("b2b_same_cycle", 32'(both_seen), 32'd1);

    // Reset in the cycle after an AW handshake, with W still pending
    p0w = wpulses; b0 = bcount;
    drive_aw(15'h3000);
    @(negedge clk);
    axi.awvalid = 1'b0;
    drive_w(32'h7777_7777, 4'hF);
    rstn = 1'b0;
    #1;
    check("midrst_awready", 32'(axi.awready), 32'd0);
    check("midrst_wready", 32'(axi.wready), 32'd0);
    check("midrst_bvalid", 32'(axi.bvalid), 32'd0);
    check("midrst_waddr", 32'(axil_waddr), 32'd0);
    axi.wvalid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_pulse", 32'(wpulses - p0w), 32'd0);
    check("midrst_no_b", 32'(bcount - b0), 32'd0);
    check("midrst_ready", 32'({axi.awready, axi.wready}), 32'h3);
    do_write('{15'h3008, 32'h0BAD_F00D, 4'h6, 0, 15'h3008});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
